rv32_mdu: RTL and testbench

// - Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs.
// - Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU using one radix-2 step per cycle.
// - Drives the ID/EX register's busy input so the instruction stays frozen in EX until its result is ready.
// - Presents a one-cycle done/result pair to the EX result mux.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/rv32_mdu_if.sv | 28 ++
 rtl/rv32_mdu_step.sv | 26 ++
 rtl/rv32_mdu.sv | 127 ++++++++++++
 tb/tb_rv32_mdu.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension multiply/divide unit.
package rv32_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_ITER = 32;

endpackage

// File: rtl/rv32_mdu_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface rv32_mdu_if
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) ();
  // start requests an op with rs1/rs2/op stable while busy is high; done is a
  // single-cycle valid for result, and start is ignored in that cycle.
  logic            flush;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  mdu_state_e      dbg_state;

  modport master (
    output flush, start, op, rs1, rs2,
    input  busy, done, result, dbg_state
  );

  modport slave (
    input  flush, start, op, rs1, rs2,
    output busy, done, result, dbg_state
  );
endinterface

// File: rtl/rv32_mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring compare-subtract for divide.
module rv32_mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  // Upper half is the partial product / partial remainder; lower half holds the
  // multiplier bits still to consume, or the dividend bits turning into quotient.
  always_comb begin
    sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (acc_i[0] ? opb : {XLEN{1'b0}})};
    trial = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]} - {1'b0, opb};
    if (!is_div) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/rv32_mdu.sv
// Iterative RV32M multiply/divide unit: holds the ID/EX stage via busy, one step per cycle.
module rv32_mdu
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  rv32_mdu_if.slave   mdu
);
  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  mdu_op_e           op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  mdu_op_e           op_in;
  logic              s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, quo, rem, fin;
  logic [2*XLEN-1:0] step_acc, prod;

  rv32_mdu_step #(.XLEN(XLEN)) u_step (
    .is_div (op_q[2]),
    .acc_i  (acc_q),
    .opb    (opb_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    op_in    = mdu_op_e'(mdu.op);
    s1       = mdu.rs1[XLEN-1] & (op_in inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
    s2       = mdu.rs2[XLEN-1] & (op_in inside {MDU_MULH, MDU_DIV, MDU_REM});
    mag1     = s1 ? -mdu.rs1 : mdu.rs1;
    mag2     = s2 ? -mdu.rs2 : mdu.rs2;
    div_zero = op_in[2] & (mdu.rs2 == '0);
    div_ovf  = (op_in inside {MDU_DIV, MDU_REM}) &
               (mdu.rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (mdu.rs2 == '1);
  end

  // Result is formed from the final step output so it is registered entering DONE.
  always_comb begin
    prod = neg_q ? -step_acc : step_acc;
    quo  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem  = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    case (op_q)
      MDU_MUL:                         fin = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fin = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               fin = quo;
      default:                         fin = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    mdu.busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu.start) begin
          mdu.busy = 1'b1;
          if (div_zero) begin
            result_d = op_in[1] ? mdu.rs1 : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = op_in[1] ? '0 : mdu.rs1;
            state_d  = DONE;
          end else begin
            op_d    = op_in;
            acc_d   = {{XLEN{1'b0}}, mag1};
            opb_d   = mag2;
            neg_d   = (op_in == MDU_REM) ? s1 : (s1 ^ s2);
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        mdu.busy = 1'b1;
        acc_d    = step_acc;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MDU_ITER - 1)) begin
          result_d = fin;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mdu.flush) begin
      mdu.busy = 1'b0;
      result_d = result_q;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= MDU_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign mdu.done      = (state_q == DONE) & ~mdu.flush;
  assign mdu.result    = result_q;
  assign mdu.dbg_state = state_q;
endmodule

// File: tb/tb_rv32_mdu.sv
// Directed and randomized checks of rv32_mdu against an arithmetic RV32M reference.
module tb_rv32_mdu;
  import rv32_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rv32_mdu_if #(.XLEN(32)) mdu_if ();

  rv32_mdu #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (mdu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub, sp;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin sp = sa * sb; up = sp; return up[31:0]; end
      3'd1: begin sp = sa * sb; up = sp; return up[63:32]; end
      3'd2: begin sp = sa * ub; up = sp; return up[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issues one op with start held through DONE; operands are scrambled while it runs.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          t, busy_cnt, done_t, lat;
    logic [31:0] exp;
    exp = ref_mdu(op, a, b);
    lat = ref_latency(op, a, b);
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.op    = op;
    mdu_if.rs1   = a;
    mdu_if.rs2   = b;
    t = 0; busy_cnt = 0; done_t = -1;
    while (t < 40) begin
      #1;
      if (mdu_if.busy) busy_cnt++;
      if (mdu_if.done) begin
        done_t = t;
        break;
      end
      @(negedge clk);
      t++;
      mdu_if.rs1 = $urandom;
      mdu_if.rs2 = $urandom;
    end
    check($sformatf("latency op%0d", op), done_t, lat);
    check($sformatf("busy_cycles op%0d", op), busy_cnt, lat);
    check($sformatf("result op%0d %h %h", op, a, b), mdu_if.result, exp);
    @(negedge clk);
    mdu_if.start = 1'b0;
    #1;
    check("single_done", {31'b0, mdu_if.done}, 32'h0);
    check("result_hold", mdu_if.result, exp);
  endtask

  initial begin
    logic [31:0] prev;
    int          done_seen;
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    mdu_if.flush = 1'b0;
    mdu_if.start = 1'b0;
    mdu_if.op    = 3'd0;
    mdu_if.rs1   = 32'h0;
    mdu_if.rs2   = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", {31'b0, mdu_if.busy}, 32'h0);
    check("reset_done", {31'b0, mdu_if.done}, 32'h0);
    check("reset_result", mdu_if.result, 32'h0);
    check("reset_state", 32'(mdu_if.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end

    // Flush a DIVU ten cycles in.
    prev = mdu_if.result;
    done_seen = 0;
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.op    = 3'd5;
    mdu_if.rs1   = 32'd1000;
    mdu_if.rs2   = 32'd3;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (mdu_if.done) done_seen++;
      @(negedge clk);
    end
    mdu_if.flush = 1'b1;
    #1;
    check("flush_busy", {31'b0, mdu_if.busy}, 32'h0);
    @(negedge clk);
    mdu_if.flush = 1'b0;
    mdu_if.start = 1'b0;
    #1;
    check("flush_state", 32'(mdu_if.dbg_state), 32'(IDLE));
    check("flush_result", mdu_if.result, prev);
    for (int t = 0; t < 40; t++) begin
      if (mdu_if.done) done_seen++;
      @(negedge clk);
      #1;
    end
    check("flush_no_done", done_seen, 32'h0);
    run_op(3'd0, 32'd3, 32'd4);

    // Reset in the middle of a multiply.
    @(negedge clk);
    mdu_if.start = 1'b1;
    mdu_if.op    = 3'd0;
    mdu_if.rs1   = 32'h1234_5678;
    mdu_if.rs2   = 32'h9ABC_DEF0;
    repeat (5) @(negedge clk);
    rst_n        = 1'b0;
    mdu_if.start = 1'b0;
    #1;
    check("midrst_busy", {31'b0, mdu_if.busy}, 32'h0);
    check("midrst_done", {31'b0, mdu_if.done}, 32'h0);
    check("midrst_result", mdu_if.result, 32'h0);
    check("midrst_state", 32'(mdu_if.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    run_op(3'd6, 32'h8000_0001, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
